dm_responder: RTL and testbench

Handshaked data-memory responder: the memory-side end of the CPU load/store interface. It accepts one request at a time from the core's memory stage (word address, write data, byte enables), models a fixed multi-cycle access latency, commits writes or reads the word, then holds a response until the requester takes it. It replaces the single-cycle data memory once the core moves to a stalling or multi-cycle datapath.

---
 rtl/dm_responder_if.sv | 24 ++
 rtl/dm_responder.sv | 119 +++++++++++
 tb/tb_dm_responder.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/dm_responder_if.sv
// Load/store bus between the core's memory stage (master) and the data-memory responder (slave).
// Requests and responses each use a valid/ready pair that completes on a rising edge where both are high.
interface dm_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dm_responder.sv
// Multi-cycle data memory: accepts one request, waits LATENCY cycles, commits the access,
// then holds the response until the requester takes it.
module dm_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic           clk,
    input  logic           reset,
    dm_responder_if.slave  bus,
    output logic [1:0]     dbg_state_o
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [31:0]           addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            be_q, be_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [31:0]           mem_q [DEPTH];

    logic                  mem_we;
    logic                  addr_bad;
    logic [ADDR_WIDTH-1:0] word_idx;

    assign word_idx = addr_q[ADDR_WIDTH+1:2];
    assign addr_bad = (addr_q[1:0] != 2'b00) || (addr_q[31:ADDR_WIDTH+2] != '0);

    assign bus.req_ready = (state_q == S_IDLE) && !reset;
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign dbg_state_o   = state_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid && bus.req_ready) begin
                    we_d    = bus.req_we;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    be_d    = bus.req_be;
                    cnt_d   = 4'd0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 4'd1;
                // Commit edge: the read is captured here so the response stays frozen in RESP.
                if (cnt_q == 4'(LATENCY - 1)) begin
                    err_d   = addr_bad;
                    rdata_d = (!addr_bad && !we_q) ? mem_q[word_idx] : 32'h0;
                    mem_we  = we_q && !addr_bad;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            be_q    <= 4'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Reset clears the whole array, so a committed store does not survive a reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'h0;
            end
        end else if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem_q[word_idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: three instances (LATENCY 2, 1, 4) share stimulus,
// one is selected for observation at a time.
module tb_dm_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [3:0]  req_be = 4'h0;
    logic        rsp_ready = 1'b0;

    logic [2:0]  rv_a, rdy_a, err_a;
    logic [31:0] rd_a [3];
    logic [1:0]  dbg_a [3];

    int          sel = 0;
    int          errors = 0;
    int          checks = 0;

    logic        cur_rv, cur_rdy, cur_err;
    logic [31:0] cur_rd;

    always #5 clk = ~clk;

    dm_responder_if bus [3] ();

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT_G = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
        assign bus[g].req_valid = req_valid;
        assign bus[g].req_we    = req_we;
        assign bus[g].req_addr  = req_addr;
        assign bus[g].req_wdata = req_wdata;
        assign bus[g].req_be    = req_be;
        assign bus[g].rsp_ready = rsp_ready;
        assign rv_a[g]  = bus[g].rsp_valid;
        assign rdy_a[g] = bus[g].req_ready;
        assign err_a[g] = bus[g].rsp_err;
        assign rd_a[g]  = bus[g].rsp_rdata;

        dm_responder #(.ADDR_WIDTH(10), .LATENCY(LAT_G)) u_dut (
            .clk         (clk),
            .reset       (reset),
            .bus         (bus[g]),
            .dbg_state_o (dbg_a[g])
        );
    end

    always_comb begin
        cur_rv  = rv_a[sel];
        cur_rdy = rdy_a[sel];
        cur_err = err_a[sel];
        cur_rd  = rd_a[sel];
    end

    function automatic int lat_of(int s);
        return (s == 0) ? 2 : ((s == 1) ? 1 : 4);
    endfunction

    task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (lat=%0d): got 0x%08h expected 0x%08h", tag, lat_of(sel), act, exp);
        end
    endtask

    task automatic wait_rv(output int k);
        k = 0;
        while (!cur_rv && k < 40) begin
            @(negedge clk);
            k++;
        end
    endtask

    // Full transaction; req_valid stays high until after the response handshake.
    task automatic do_req(string tag, bit we, logic [31:0] addr, logic [31:0] wdata,
                          logic [3:0] be, logic [31:0] exp_rd, bit exp_err, int stall);
        int k;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        k = 0;
        while (!cur_rdy && k < 20) begin
            @(negedge clk);
            k++;
        end
        check({tag, " req_ready"}, 32'(cur_rdy), 32'd1);
        @(posedge clk);
        @(negedge clk);
        wait_rv(k);
        check({tag, " latency"}, k, lat_of(sel));
        check({tag, " rdata"}, cur_rd, exp_rd);
        check({tag, " err"}, 32'(cur_err), 32'(exp_err));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({tag, " hold rsp_valid"}, 32'(cur_rv), 32'd1);
            check({tag, " hold rdata"}, cur_rd, exp_rd);
            check({tag, " hold err"}, 32'(cur_err), 32'(exp_err));
            check({tag, " hold req_ready"}, 32'(cur_rdy), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check({tag, " req_ready after rsp"}, 32'(cur_rdy), 32'd1);
        check({tag, " rsp_valid after rsp"}, 32'(cur_rv), 32'd0);
        rsp_ready = 1'b0;
        req_valid = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset     = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("req_ready in reset", 32'(cur_rdy), 32'd0);
        reset = 1'b0;
        #1;
        check("req_ready after reset", 32'(cur_rdy), 32'd1);
    endtask

    initial begin
        int k;
        // Reset state
        @(negedge clk);
        check("rst rsp_valid", 32'(cur_rv), 32'd0);
        check("rst req_ready", 32'(cur_rdy), 32'd0);
        check("rst rdata", cur_rd, 32'h0);
        check("rst err", 32'(cur_err), 32'd0);
        reset = 1'b0;
        #1;
        check("req_ready after release", 32'(cur_rdy), 32'd1);
        do_req("ld 0x10", 1'b0, 32'h10, 32'h0, 4'h0, 32'h0, 1'b0, 0);

        // Store/load round trip
        do_req("st 0x40", 1'b1, 32'h40, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 0);
        do_req("ld 0x40", 1'b0, 32'h40, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 0);

        // Asynchronous reset while a response is pending
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h40;
        req_be    = 4'h0;
        @(posedge clk);
        @(negedge clk);
        wait_rv(k);
        check("pre-reset rdata", cur_rd, 32'hDEADBEEF);
        #2 reset = 1'b1;
        #1;
        check("async rst rsp_valid", 32'(cur_rv), 32'd0);
        check("async rst rdata", cur_rd, 32'h0);
        check("async rst err", 32'(cur_err), 32'd0);
        check("async rst req_ready", 32'(cur_rdy), 32'd0);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("req_ready after async rst", 32'(cur_rdy), 32'd1);
        do_req("ld 0x40 wiped", 1'b0, 32'h40, 32'h0, 4'h0, 32'h0, 1'b0, 0);
        do_req("st 0x40 again", 1'b1, 32'h40, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 0);

        // Byte enables
        do_req("st 0x8 full", 1'b1, 32'h8, 32'h11223344, 4'hF, 32'h0, 1'b0, 0);
        do_req("st 0x8 be5", 1'b1, 32'h8, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0, 0);
        do_req("ld 0x8 merged", 1'b0, 32'h8, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, 0);
        do_req("st 0x8 be0", 1'b1, 32'h8, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0, 0);
        do_req("ld 0x8 after be0", 1'b0, 32'h8, 32'h0, 4'h3, 32'h11BB33DD, 1'b0, 0);

        // Errors and range boundaries
        do_req("ld 0x42 misaligned", 1'b0, 32'h42, 32'h0, 4'hF, 32'h0, 1'b1, 0);
        do_req("st 0x1000 range", 1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, 32'h0, 1'b1, 0);
        do_req("ld 0x0 untouched", 1'b0, 32'h0, 32'h0, 4'hF, 32'h0, 1'b0, 0);
        do_req("ld 0x80000040 range", 1'b0, 32'h80000040, 32'h0, 4'hF, 32'h0, 1'b1, 0);
        do_req("st 0xFFC top", 1'b1, 32'hFFC, 32'h5A5A5A5A, 4'hF, 32'h0, 1'b0, 0);
        do_req("ld 0xFFC top", 1'b0, 32'hFFC, 32'h0, 4'hF, 32'h5A5A5A5A, 1'b0, 0);

        // Backpressure with req_valid held high
        do_req("backpressure", 1'b0, 32'h40, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, 5);

        // Reset mid-WAIT and reset after commit, for each latency
        for (int s = 0; s < 3; s++) begin
            sel = s;
            apply_reset();
            @(negedge clk);
            req_valid = 1'b1;
            req_we    = 1'b1;
            req_addr  = 32'h20;
            req_wdata = 32'h12345678;
            req_be    = 4'hF;
            @(posedge clk);
            @(negedge clk);
            reset     = 1'b1;
            req_valid = 1'b0;
            @(negedge clk);
            reset = 1'b0;
            do_req("ld 0x20 after mid-wait rst", 1'b0, 32'h20, 32'h0, 4'hF, 32'h0, 1'b0, 0);
            do_req("st 0x20", 1'b1, 32'h20, 32'h12345678, 4'hF, 32'h0, 1'b0, 0);
            do_req("ld 0x20", 1'b0, 32'h20, 32'h0, 4'hF, 32'h12345678, 1'b0, 0);
            apply_reset();
            do_req("ld 0x20 after commit rst", 1'b0, 32'h20, 32'h0, 4'hF, 32'h0, 1'b0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end
endmodule
